// File: rtl/icache_direct_mapped.sv
// -----------------------------------------------------------------------------
// icache_direct_mapped
//   Direct-mapped, read-only instruction cache between the HART fetch port and
//   the backing instruction memory. A hit returns in the same cycle as the
//   request. A miss refills the whole line one word per accepted beat, then
//   spends one FILL_DONE cycle before the held request hits in IDLE.
//   i_flush invalidates every line. If it arrives during a refill, the refill
//   still finishes on the bus, but the refilled line is left invalid.
//
// Ports
//   i_clk          clock, all state on rising edge
//   i_rst          asynchronous active-low reset
//   i_IC_DataReq   fetch request, held until o_IC_MemReady
//   i_IM_Addr      fetch byte address (bits [1:0] ignored)
//   o_IM_Instr     instruction word, valid with o_IC_MemReady
//   o_IC_MemReady  fetch completes this cycle
//   i_flush        invalidate all lines, one-cycle pulse
//   o_MEM_Req      refill beat request
//   o_MEM_Addr     word-aligned refill beat address
//   i_MEM_Ready    beat accepted, i_MEM_Data valid
//   i_MEM_Data     refill data word
// -----------------------------------------------------------------------------
module icache_direct_mapped #(
    parameter int XLEN       = 32,
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 64
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_IC_DataReq,
    input  logic [XLEN-1:0] i_IM_Addr,
    output logic [XLEN-1:0] o_IM_Instr,
    output logic            o_IC_MemReady,
    input  logic            i_flush,
    output logic            o_MEM_Req,
    output logic [XLEN-1:0] o_MEM_Addr,
    input  logic            i_MEM_Ready,
    input  logic [XLEN-1:0] i_MEM_Data
);

    localparam int OFF  = $clog2(LINE_WORDS);
    localparam int IDX  = $clog2(NUM_LINES);
    localparam int TAGW = XLEN - OFF - IDX - 2;

    localparam logic [XLEN-1:0] LINE_MASK = ~(XLEN'(4 * LINE_WORDS) - XLEN'(1));
    localparam logic [OFF-1:0]  BEAT_ONE  = OFF'(1);
    localparam logic [OFF-1:0]  BEAT_LAST = OFF'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_REFILL    = 2'd1,
        ST_FILL_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [XLEN-1:0]       r_base;
    logic [OFF-1:0]        r_beat;
    logic                  r_flush_pend;
    logic [NUM_LINES-1:0]  r_valid;
    logic [TAGW-1:0]       r_tag  [NUM_LINES];
    logic [XLEN-1:0]       r_data [NUM_LINES * LINE_WORDS];

    logic [OFF-1:0]        w_word;
    logic [IDX-1:0]        w_index;
    logic [TAGW-1:0]       w_tag;
    logic [IDX-1:0]        w_fill_index;
    logic                  w_hit;
    logic                  w_last_beat;

    assign w_word       = i_IM_Addr[OFF+1:2];
    assign w_index      = i_IM_Addr[OFF+IDX+1:OFF+2];
    assign w_tag        = i_IM_Addr[XLEN-1:OFF+IDX+2];
    assign w_fill_index = r_base[OFF+IDX+1:OFF+2];
    assign w_hit        = r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_last_beat  = (r_beat == BEAT_LAST);

    // Next-state and output decode; hits answer combinationally from the arrays.
    always_comb begin
        w_next_state  = r_state;
        o_IC_MemReady = 1'b0;
        o_IM_Instr    = {XLEN{1'b0}};
        o_MEM_Req     = 1'b0;
        o_MEM_Addr    = {XLEN{1'b0}};
        case (r_state)
            ST_IDLE: begin
                if (i_IC_DataReq) begin
                    if (w_hit) begin
                        o_IC_MemReady = 1'b1;
                        o_IM_Instr    = r_data[{w_index, w_word}];
                        w_next_state  = ST_IDLE;
                    end else begin
                        w_next_state  = ST_REFILL;
                    end
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_REFILL: begin
                o_MEM_Req  = 1'b1;
                // Address math wraps modulo 2^XLEN by construction.
                o_MEM_Addr = r_base + {{(XLEN-OFF-2){1'b0}}, r_beat, 2'b00};
                if (i_MEM_Ready && w_last_beat) begin
                    w_next_state = ST_FILL_DONE;
                end else begin
                    w_next_state = ST_REFILL;
                end
            end
            ST_FILL_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Control state: FSM, refill base/beat, valid bits and pending-flush flag.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state      <= ST_IDLE;
            r_base       <= {XLEN{1'b0}};
            r_beat       <= {OFF{1'b0}};
            r_flush_pend <= 1'b0;
            r_valid      <= {NUM_LINES{1'b0}};
        end else begin
            r_state <= w_next_state;
            case (r_state)
                ST_IDLE: begin
                    if (i_IC_DataReq && !w_hit) begin
                        r_base <= i_IM_Addr & LINE_MASK;
                        r_beat <= {OFF{1'b0}};
                    end
                    r_flush_pend <= 1'b0;
                    // Same-cycle hit already read the pre-flush state.
                    if (i_flush) begin
                        r_valid <= {NUM_LINES{1'b0}};
                    end
                end
                ST_REFILL: begin
                    if (i_MEM_Ready) begin
                        if (w_last_beat) begin
                            r_beat <= {OFF{1'b0}};
                        end else begin
                            r_beat <= r_beat + BEAT_ONE;
                        end
                    end
                    // Flush mid-refill: let the bus finish, poison the line.
                    if (i_flush) begin
                        r_valid      <= {NUM_LINES{1'b0}};
                        r_flush_pend <= 1'b1;
                    end
                end
                ST_FILL_DONE: begin
                    if (i_flush) begin
                        r_valid <= {NUM_LINES{1'b0}};
                    end else begin
                        r_valid[w_fill_index] <= ~r_flush_pend;
                    end
                    r_flush_pend <= 1'b0;
                end
                default: begin
                    r_flush_pend <= 1'b0;
                end
            endcase
        end
    end

    // Line storage: data words per accepted beat, tag on the final beat (no reset).
    always_ff @(posedge i_clk) begin
        if ((r_state == ST_REFILL) && i_MEM_Ready) begin
            r_data[{w_fill_index, r_beat}] <= i_MEM_Data;
            if (w_last_beat) begin
                r_tag[w_fill_index] <= r_base[XLEN-1:OFF+IDX+2];
            end
        end
    end

endmodule
